// File: rtl/mic_meter_pkg.sv
// Shared types and colour constants for the mic volume meter.
// The peak-hold marker is enabled with the MIC_METER_PEAK_HOLD_EN macro.
package mic_meter_pkg;

  localparam logic [15:0] C_BLACK    = 16'h0000;
  localparam logic [15:0] C_WHITE    = 16'hFFFF;
  localparam logic [15:0] C_GREEN    = 16'h07E0;
  localparam logic [15:0] C_YELLOW   = 16'hFFE0;
  localparam logic [15:0] C_RED      = 16'hF800;
  localparam logic [15:0] C_MAGENTA  = 16'hF81F;
  localparam logic [15:0] C_BLUE     = 16'h001F;
  localparam logic [15:0] C_ORANGE   = 16'hFC00;
  localparam logic [15:0] C_OLIVE    = 16'h8204;
  localparam logic [15:0] C_SKY      = 16'h5FFF;

  typedef struct packed {
    logic [15:0] green;
    logic [15:0] orange;
    logic [15:0] red;
    logic [15:0] bg;
    logic [15:0] peak;
  } theme_t;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    FALL
  } peak_state_t;

  function automatic theme_t theme_lut(input logic [1:0] theme_sw);
    theme_t t;
    case (theme_sw)
      2'b00:   t = '{green: C_GREEN,   orange: C_YELLOW,  red: C_RED,     bg: C_BLACK, peak: C_WHITE};
      2'b01:   t = '{green: C_MAGENTA, orange: C_BLUE,    red: C_ORANGE,  bg: C_WHITE, peak: C_BLACK};
      2'b10:   t = '{green: C_YELLOW,  orange: C_GREEN,   red: C_MAGENTA, bg: C_BLUE,  peak: C_WHITE};
      default: t = '{green: C_OLIVE,   orange: C_MAGENTA, red: C_BLUE,    bg: C_SKY,   peak: C_BLACK};
    endcase
    return t;
  endfunction

endpackage

// File: rtl/mic_meter_ballistics.sv
// Meter dynamics: instant-attack / timed-decay bar level and, when
// MIC_METER_PEAK_HOLD_EN is defined, the peak-hold marker FSM.
module mic_meter_ballistics
  import mic_meter_pkg::*;
#(
  parameter int VOL_W        = 5,
  parameter int NUM_BARS     = 6,
  parameter int DECAY_FRAMES = 4,
  parameter int HOLD_FRAMES  = 30,
  parameter int LVL_W        = $clog2(NUM_BARS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic [VOL_W-1:0] volume,
`ifdef MIC_METER_PEAK_HOLD_EN
  output logic [LVL_W-1:0] peak,
`endif
  output logic [LVL_W-1:0] level
);

  localparam int TW   = VOL_W + 4;
  localparam int DC_W = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;

  logic [TW-1:0]    prod;
  logic [LVL_W-1:0] target;
  logic [LVL_W-1:0] level_nxt;
  logic [DC_W-1:0]  decay_cnt;
  logic [DC_W-1:0]  decay_nxt;

  assign prod   = ((TW)'(volume) + (TW)'(1)) * (TW)'(NUM_BARS);
  assign target = LVL_W'(prod >> VOL_W);

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    level_nxt = level;
    decay_nxt = decay_cnt;
    if (target >= level) begin
      level_nxt = target;
      decay_nxt = '0;
    end else if (decay_cnt == DC_W'(DECAY_FRAMES - 1)) begin
      level_nxt = level - LVL_W'(1);
      decay_nxt = '0;
    end else begin
      decay_nxt = decay_cnt + DC_W'(1);
    end
  end

`ifdef MIC_METER_PEAK_HOLD_EN
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

  peak_state_t       state;
  logic [HOLD_W-1:0] hold_cnt;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      level     <= '0;
      decay_cnt <= '0;
`ifdef MIC_METER_PEAK_HOLD_EN
      peak      <= '0;
      hold_cnt  <= '0;
      state     <= IDLE;
`endif
    end else if (frame_tick) begin
      level     <= level_nxt;
      decay_cnt <= decay_nxt;
`ifdef MIC_METER_PEAK_HOLD_EN
      // The marker tracks the freshly updated level, so it never sits below it.
      case (state)
        IDLE: begin
          if (level_nxt != '0) begin
            peak     <= level_nxt;
            hold_cnt <= HOLD_W'(HOLD_FRAMES);
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (level_nxt >= peak) begin
            peak     <= level_nxt;
            hold_cnt <= HOLD_W'(HOLD_FRAMES);
          end else if (hold_cnt == '0) begin
            state <= FALL;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end
        FALL: begin
          if (level_nxt >= peak) begin
            peak     <= level_nxt;
            hold_cnt <= HOLD_W'(HOLD_FRAMES);
            state    <= HOLD;
          end else begin
            peak <= peak - LVL_W'(1);
            if (peak == LVL_W'(1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
`endif
    end
  end

endmodule

// File: rtl/mic_volume_meter.sv
// Stacked-bar mic volume meter for the 96x64 OLED with registered RGB565 output.
// Define MIC_METER_PEAK_HOLD_EN to add the peak-hold marker.
module mic_volume_meter
  import mic_meter_pkg::*;
#(
  parameter int VOL_W        = 5,
  parameter int NUM_BARS     = 6,
  parameter int BAR_H        = 5,
  parameter int X_MIN        = 18,
  parameter int X_MAX        = 77,
  parameter int Y_BOTTOM     = 46,
  parameter int DECAY_FRAMES = 4,
  parameter int HOLD_FRAMES  = 30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic [VOL_W-1:0] volume,
  input  logic [6:0]       x,
  input  logic [5:0]       y,
  input  logic [1:0]       theme_sw,
  output logic [15:0]      oled_data
);

  localparam int LVL_W = $clog2(NUM_BARS + 1);

  logic [LVL_W-1:0] level;
  theme_t           theme;
  logic [15:0]      pixel;
  logic             in_bar;
  int               xi;
  int               yi;
  int               bar;

`ifdef MIC_METER_PEAK_HOLD_EN
  logic [LVL_W-1:0] peak;
`else
  logic unused_peak_colour;
  assign unused_peak_colour = ^theme.peak;
`endif

  mic_meter_ballistics #(
    .VOL_W        (VOL_W),
    .NUM_BARS     (NUM_BARS),
    .DECAY_FRAMES (DECAY_FRAMES),
    .HOLD_FRAMES  (HOLD_FRAMES),
    .LVL_W        (LVL_W)
  ) u_ballistics (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .volume     (volume),
`ifdef MIC_METER_PEAK_HOLD_EN
    .peak       (peak),
`endif
    .level      (level)
  );

  always_comb begin
    theme  = theme_lut(theme_sw);
    xi     = int'(x);
    yi     = int'(y);
    in_bar = 1'b0;
    bar    = 0;
    pixel  = theme.bg;
    // Bars stack upward from Y_BOTTOM; bar index is the row offset divided by bar height.
    if (xi >= X_MIN && xi <= X_MAX && yi <= Y_BOTTOM && yi > Y_BOTTOM - NUM_BARS * BAR_H) begin
      in_bar = 1'b1;
      bar    = (Y_BOTTOM - yi) / BAR_H;
    end
    if (in_bar) begin
`ifdef MIC_METER_PEAK_HOLD_EN
      if (peak != '0 && bar == int'(peak) - 1) begin
        pixel = theme.peak;
      end else
`endif
      if (bar < int'(level)) begin
        if (3 * bar < NUM_BARS)          pixel = theme.green;
        else if (3 * bar < 2 * NUM_BARS) pixel = theme.orange;
        else                             pixel = theme.red;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) oled_data <= 16'h0000;
    else       oled_data <= pixel;
  end

endmodule
